// File: rtl/rr_grant_fsm.sv
// -----------------------------------------------------------------------------
// rr_grant_fsm
// Round-robin arbiter implemented as a two-state Moore machine (IDLE / GRANT).
// One of N requesters owns a shared downstream resource at a time. Fairness
// comes from a rotating priority pointer and a bounded hold time, so a steady
// requester waits at most (N-1)*MAX_HOLD cycles.
//
// Parameters:
//   N         number of requesters (2..16)
//   MAX_HOLD  max consecutive cycles an owner keeps the grant under contention
//             (>= 1)
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high reset
//   req[N-1:0]   level request, bit i = requester i
//   grant[N-1:0] registered one-hot grant, all-zero when idle
//   grant_valid  high iff grant is nonzero
//   grant_id     index of the current owner, 0 when idle
// -----------------------------------------------------------------------------
module rr_grant_fsm #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N-1:0]         req,
   output logic [N-1:0]         grant,
   output logic                 grant_valid,
   output logic [$clog2(N)-1:0] grant_id
);

   localparam int IW = $clog2(N);
   localparam int HW = $clog2(MAX_HOLD) + 1;

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_GRANT = 1'b1;

   // Registered state
   logic [0:0]    state_reg,    state_next;
   logic [IW-1:0] owner_reg,    owner_next;
   logic [IW-1:0] ptr_reg,      ptr_next;
   logic [HW-1:0] hold_cnt_reg, hold_cnt_next;
   logic [N-1:0]  grant_reg,    grant_next;
   logic          valid_reg,    valid_next;
   logic [IW-1:0] id_reg,       id_next;

   // Decoded helpers
   logic [N-1:0]  others;
   logic [IW-1:0] owner_inc;
   logic [IW-1:0] idle_pick;
   logic [IW-1:0] handoff_pick;
   logic          owner_req;
   logic          hold_last;

   // First set bit of r, searching upward from start and wrapping modulo N.
   // The loop runs downward so the lowest offset is the last (winning) write.
   // With r == 0 the result is meaningless; callers gate it with |r.
   function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] r,
                                             input logic [IW-1:0] start);
      logic [IW-1:0] sel;
      int            idx;
      sel = start;
      for (int k = N - 1; k >= 0; k--) begin
         idx = int'(start) + k;
         if (idx >= N) begin
            idx = idx - N;
         end
         if (r[idx]) begin
            sel = IW'(idx);
         end
      end
      return sel;
   endfunction

   function automatic logic [N-1:0] onehot(input logic [IW-1:0] i);
      logic [N-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   // Requests from everyone except the current owner.
   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_others
         assign others[gi] = req[gi] & (owner_reg != IW'(gi));
      end
   endgenerate

   // Explicit wrap so non-power-of-two N never produces an index >= N.
   assign owner_inc    = (owner_reg == IW'(N - 1)) ? '0 : owner_reg + IW'(1);
   assign idle_pick    = rr_pick(req, ptr_reg);
   assign handoff_pick = rr_pick(others, owner_inc);
   assign owner_req    = req[owner_reg];
   assign hold_last    = (hold_cnt_reg == HW'(MAX_HOLD - 1));

   always_comb begin
      state_next    = state_reg;
      owner_next    = owner_reg;
      ptr_next      = ptr_reg;
      hold_cnt_next = hold_cnt_reg;

      case (state_reg)
         S_IDLE: begin
            if (|req) begin
               state_next    = S_GRANT;
               owner_next    = idle_pick;
               hold_cnt_next = '0;
            end
         end
         default: begin
            if (!owner_req) begin
               // Release: hand off with no bubble, or fall back to IDLE.
               ptr_next      = owner_inc;
               hold_cnt_next = '0;
               if (|others) begin
                  owner_next = handoff_pick;
               end else begin
                  state_next = S_IDLE;
               end
            end else if (hold_last) begin
               // Hold budget spent: rotate if contended, otherwise restart it.
               hold_cnt_next = '0;
               if (|others) begin
                  owner_next = handoff_pick;
                  ptr_next   = owner_inc;
               end
            end else begin
               hold_cnt_next = hold_cnt_reg + HW'(1);
            end
         end
      endcase

      // Outputs are registered alongside the state so they stay consistent.
      if (state_next == S_GRANT) begin
         grant_next = onehot(owner_next);
         valid_next = 1'b1;
         id_next    = owner_next;
      end else begin
         grant_next = '0;
         valid_next = 1'b0;
         id_next    = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= S_IDLE;
         owner_reg    <= '0;
         ptr_reg      <= '0;
         hold_cnt_reg <= '0;
         grant_reg    <= '0;
         valid_reg    <= 1'b0;
         id_reg       <= '0;
      end else begin
         state_reg    <= state_next;
         owner_reg    <= owner_next;
         ptr_reg      <= ptr_next;
         hold_cnt_reg <= hold_cnt_next;
         grant_reg    <= grant_next;
         valid_reg    <= valid_next;
         id_reg       <= id_next;
      end
   end

   assign grant       = grant_reg;
   assign grant_valid = valid_reg;
   assign grant_id    = id_reg;

endmodule
